// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_ctrl_pkg
// Description : Shared types, mode encodings and helpers for the PE
//               shift-and-add accumulation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

   localparam int ACC_W_DEF = 20;
   localparam int LEN_W_DEF = 8;

   // Precision mode encodings
   localparam logic [1:0] c_MODE_1P  = 2'd0;
   localparam logic [1:0] c_MODE_2P  = 2'd1;
   localparam logic [1:0] c_MODE_4P  = 2'd2;
   localparam logic [1:0] c_MODE_RSV = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of temporal phases per vector for a given mode; the reserved
   // encoding behaves as single-phase.
   function automatic logic [2:0] phase_count(input logic [1:0] mode);
      logic [2:0] n;
      n = 3'd1;
      case (mode)
         c_MODE_2P: n = 3'd2;
         c_MODE_4P: n = 3'd4;
         default:   n = 3'd1;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_shift_sel.sv
`default_nettype none
// ============================================================================
// Module      : pe_shift_sel
// Description : Combinational decoder from (mode, phase) to the adder's
//               four 2-bit group-shift selects.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_shift_sel
   import pe_ctrl_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [1:0] phase,
   output logic [7:0] sum_signal
);

   // One select field per group; upper groups lead by one step in 2-phase mode
   generate
      for (genvar g = 0; g < 4; g++) begin : g_grp
         localparam logic [1:0] c_GRP_HI = 2'(g / 2);
         assign sum_signal[2*g+1:2*g] = (mode == c_MODE_2P) ? (c_GRP_HI + phase) :
                                        (mode == c_MODE_4P) ? phase : 2'd0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pe_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_accum_ctrl
// Description : Sequencing controller for the PE shift-and-add datapath.
//               Drives group-shift selects and feedback sum, accumulates
//               cfg_len vectors over 1/2/4 phases, and returns the result on
//               a valid/ready output.
//               Optional macro PE_CTRL_STAT_EN adds the stat_stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_accum_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cfg_mode,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       sum_signal,
   output logic [ACC_W-1:0] adder_prev_sum,
   input  logic [ACC_W-1:0] adder_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy,
   output logic             cfg_err
`ifdef PE_CTRL_STAT_EN
   ,
   output logic [15:0]      stat_stall_cnt
`endif
);

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_len;
   logic [1:0]       r_phase;
   logic [LEN_W-1:0] r_vec;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_cfg_err;

   logic             w_beat;
   logic             w_last_phase;
   logic             w_last_vec;
   logic [2:0]       w_nph;
   logic [7:0]       w_sel;

   assign w_nph        = phase_count(r_mode);
   assign w_beat       = in_valid && r_in_ready;
   assign w_last_phase = ({1'b0, r_phase} == (w_nph - 3'd1));
   assign w_last_vec   = (r_vec == (r_len - 1'b1));

   pe_shift_sel u_shift_sel (
      .mode       (r_mode),
      .phase      (r_phase),
      .sum_signal (w_sel)
   );

   // Selects are only meaningful while beats are being accepted
   assign sum_signal     = (r_state == ST_RUN) ? w_sel : 8'h00;
   // Accumulator is cleared on start, so the first beat of a job sees zero
   assign adder_prev_sum = r_acc;
   assign in_ready       = r_in_ready;
   assign out_valid      = r_out_valid;
   assign out_sum        = r_out_sum;
   assign busy           = r_busy;
   assign cfg_err        = r_cfg_err;

   // Job FSM: configuration latch, phase/vector counters, accumulator, outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mode      <= c_MODE_1P;
         r_len       <= '0;
         r_phase     <= 2'd0;
         r_vec       <= '0;
         r_acc       <= '0;
         r_out_sum   <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cfg_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode    <= (cfg_mode == c_MODE_RSV) ? c_MODE_1P : cfg_mode;
                  r_len     <= cfg_len;
                  r_phase   <= 2'd0;
                  r_vec     <= '0;
                  r_acc     <= '0;
                  r_cfg_err <= (cfg_mode == c_MODE_RSV);
                  r_busy    <= 1'b1;
                  if (cfg_len == '0) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_out_sum   <= '0;
                  end else begin
                     r_state    <= ST_RUN;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_beat) begin
                  r_acc <= adder_sum;
                  if (w_last_phase) begin
                     r_phase <= 2'd0;
                     if (w_last_vec) begin
                        r_state     <= ST_DONE;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_sum   <= adder_sum;
                     end else begin
                        r_vec <= r_vec + 1'b1;
                     end
                  end else begin
                     r_phase <= r_phase + 2'd1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef PE_CTRL_STAT_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of RUN cycles with no operand beat offered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_stall_cnt <= 16'd0;
      end else if ((r_state == ST_RUN) && !in_valid && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/pe_accum_ctrl.md
# pe_accum_ctrl

Sequencing controller for the PE shift-and-add datapath. It drives the adder's 8-bit `sum_signal` group-shift selects and its 20-bit `previous_sum` feedback, and holds the running accumulator across precision phases and input vectors. One job accumulates `len` vectors, using 1, 2 or 4 temporal phases per vector according to the precision mode, then presents the result on a valid/ready output. It sits between the PE array's operand feeder and the PE adder, one instance per PE.

## Interface
- `ACC_W`, 20, accumulator and adder sum width.
- `LEN_W`, 8, vector-count width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_mode`  in  2  precision mode, latched on `start`: 0 = 1 phase, 1 = 2 phases, 2 = 4 phases, 3 = reserved.
- `cfg_len`  in  LEN_W  vectors per job, latched on `start`.
- `in_valid`  in  1  operand beat (one phase) present at the adder inputs.
- `in_ready`  out  1  controller accepts the beat.
- `sum_signal`  out  8  to adder; field `[2g+1:2g]` is the shift select for group g (shift = field*4).
- `adder_prev_sum`  out  ACC_W  to adder `previous_sum`.
- `adder_sum`  in  ACC_W  from adder `PE_sum`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed.
- `out_sum`  out  ACC_W  job result.
- `busy`  out  1  high in RUN or DONE.
- `cfg_err`  out  1  one-cycle pulse when `start` is accepted with `cfg_mode==3`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=0, `busy`=0.
  - `start` latches mode and len and clears the phase counter, vector counter and accumulator.
  - Next state is RUN, or DONE if `cfg_len==0`.
- Mode 3 runs as mode 0 and pulses `cfg_err` for one cycle.
- RUN: `in_ready`=1. A beat is `in_valid && in_ready`. On a beat:
  - `acc <= adder_sum`.
  - phase increments.
  - At phase P-1, phase returns to 0 and the vector counter increments.
  - The beat that is both the last phase and the last vector moves the FSM to DONE.
- `adder_prev_sum` = 0 on the first beat of a job, otherwise `acc`.
- `sum_signal` field for group g in phase p:
  - mode 0: 0.
  - mode 1: (g>>1)+p.
  - mode 2: p.
  - `sum_signal` is 8'h00 outside RUN.
- DONE: `out_valid`=1 and `out_sum`=`acc`. `out_ready` returns the FSM to IDLE.
- `start` is ignored in RUN and DONE.
- Arithmetic is the adder's, modulo 2^ACC_W. The controller stores `adder_sum` unmodified; no saturation.

## Timing
- Reset values: FSM=IDLE; `acc`, counters, `out_sum`, `sum_signal`, `adder_prev_sum`=0; `in_ready`, `out_valid`, `busy`, `cfg_err`=0. Reset applies immediately, including mid-job; the partial sum is discarded.
- `start` to first possible beat: 1 cycle (RUN in the next cycle).
- Final beat to `out_valid`: 1 cycle. `out_valid` and `out_sum` are registered and held stable until `out_ready`.
- `len==0`: `out_valid` 1 cycle after `start`, `out_sum`=0, no beats consumed.
- `in_ready` and `sum_signal` decode from registered state only; there is no combinational path from `in_valid`.
- A new `start` is accepted no earlier than the cycle after the DONE→IDLE handshake.

## Configuration
- `PE_CTRL_STAT_EN` defined:
  - Adds output `stat_stall_cnt` [15:0], counting RUN cycles with `in_valid`=0.
  - Saturates at 16'hFFFF, clears on accepted `start`, reset value 0.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package `pe_ctrl_pkg`:
  - mode encodings and state enum;
  - `ACC_W` default;
  - function mapping mode → phase count (1/2/4).
- Sub-module `pe_shift_sel`: combinational (mode, phase) → `sum_signal` decoder.
- The FSM, counters and accumulator stay in `pe_accum_ctrl`.

## Test plan
- Mode 0, len=3, bench `adder_sum = adder_prev_sum + 5`, `in_valid` held high:
  - three beats, `sum_signal`=8'h00 each;
  - first `adder_prev_sum`=0;
  - `out_valid` one cycle after beat 3 with `out_sum`=15.
- `sum_signal` sequences:
  - Mode 2, len=1: 8'h00, 8'h55, 8'hAA, 8'hFF on four beats.
  - Mode 1, len=2: 8'h50, 8'hA5, 8'h50, 8'hA5.
- `cfg_len`=0: `out_valid` the cycle after `start`, `out_sum`=0, `in_ready` never high.
- Output backpressure: hold `out_ready` low 5 cycles.
  - `out_valid` and `out_sum` stay stable.
  - `start` pulses are ignored.
  - `out_ready` returns the FSM to IDLE.
- Reset mid-job: assert `rst` after 2 of 4 beats.
  - All outputs go to 0 immediately.
  - The next job's first `adder_prev_sum`=0.
- Mode 3 start: `cfg_err` pulses once and the job runs with `sum_signal`=8'h00. With `PE_CTRL_STAT_EN`, dropping `in_valid` for 3 RUN cycles gives `stat_stall_cnt`=3.
